// File: rtl/apb_mem_ws_if.sv
// APB3 bus bundle for apb_mem_ws.
// Optional byte strobes are present only when APB_MEM_PSTRB_EN is defined.
interface apb_mem_ws_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 8
);
   logic              PSEL;
   logic              PENABLE;
   logic              PWRITE;
   logic [ADDR_W-1:0] PADDR;
   logic [DATA_W-1:0] PWDATA;
`ifdef APB_MEM_PSTRB_EN
   logic [DATA_W/8-1:0] PSTRB;
`endif
   logic [DATA_W-1:0] PRDATA;
   logic              PREADY;
   logic              PSLVERR;

   modport master (
`ifdef APB_MEM_PSTRB_EN
      output PSTRB,
`endif
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
`ifdef APB_MEM_PSTRB_EN
      input  PSTRB,
`endif
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      output PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/apb_mem_ws.sv
// APB3 slave memory with programmable wait states, range/alignment error reporting
// and abort handling. Define APB_MEM_PSTRB_EN to add byte-lane write strobes.
module apb_mem_ws #(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned DEPTH       = 64,
   parameter int unsigned WAIT_CYCLES = 0
) (
   input logic          i_PCLK,
   input logic          i_PRESET,
   apb_mem_ws_if.slave  io_apb
);
   localparam int unsigned NBYTES = DATA_W / 8;
   localparam int unsigned LSB    = $clog2(NBYTES);
   localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((1 << LSB) - 1);
   // One extra bit so DEPTH == 2^ADDR_W still compares correctly.
   localparam logic [ADDR_W:0]   DEPTH_L    = (ADDR_W + 1)'(DEPTH);
   localparam logic [3:0]        WAIT_L     = 4'(WAIT_CYCLES);

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_ACCESS = 1'b1;

   logic [0:0]        r_state;
   logic [3:0]        r_cnt;
   logic              r_write;
   logic              r_err;
   logic [IDX_W-1:0]  r_idx;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_prdata;
   logic [DATA_W-1:0] r_mem [DEPTH];
`ifdef APB_MEM_PSTRB_EN
   logic [NBYTES-1:0] r_strb;
`endif

   logic [ADDR_W-1:0] w_index;
   logic [IDX_W-1:0]  w_idx;
   logic              w_misalign;
   logic              w_oor;
   logic              w_err;
   logic              w_setup;
   logic              w_active;
   logic              w_ready;
   logic              w_commit;

   // Address decode and error classification of the setup phase.
   always_comb begin
      w_index    = io_apb.PADDR >> LSB;
      w_idx      = w_index[IDX_W-1:0];
      w_misalign = (io_apb.PADDR & ALIGN_MASK) != '0;
      w_oor      = {1'b0, w_index} >= DEPTH_L;
`ifdef APB_MEM_PSTRB_EN
      // Reads must carry an all-zero strobe.
      w_err      = w_misalign | w_oor | (!io_apb.PWRITE && (io_apb.PSTRB != '0));
`else
      w_err      = w_misalign | w_oor;
`endif
      w_setup    = io_apb.PSEL & ~io_apb.PENABLE;
      w_active   = io_apb.PSEL & io_apb.PENABLE;
      // PREADY decodes registered state only.
      w_ready    = (r_state == ST_ACCESS) && (r_cnt == 4'd0);
      w_commit   = w_ready & w_active & r_write & ~r_err;
   end

   // Transfer state machine, request latching and read data register.
   always_ff @(posedge i_PCLK) begin
      if (i_PRESET) begin
         r_state  <= ST_IDLE;
         r_cnt    <= 4'd0;
         r_write  <= 1'b0;
         r_err    <= 1'b0;
         r_idx    <= '0;
         r_wdata  <= '0;
         r_prdata <= '0;
`ifdef APB_MEM_PSTRB_EN
         r_strb   <= '0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_setup) begin
                  r_write <= io_apb.PWRITE;
                  r_err   <= w_err;
                  r_idx   <= w_idx;
                  r_wdata <= io_apb.PWDATA;
`ifdef APB_MEM_PSTRB_EN
                  r_strb  <= io_apb.PSTRB;
`endif
                  r_cnt   <= WAIT_L;
                  r_state <= ST_ACCESS;
                  if (!io_apb.PWRITE) begin
                     r_prdata <= w_err ? '0 : r_mem[w_idx];
                  end
               end
            end
            ST_ACCESS: begin
               if (!w_active) begin
                  r_state <= ST_IDLE;  // abort: no write, no PREADY
               end else if (r_cnt != 4'd0) begin
                  r_cnt <= r_cnt - 4'd1;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Storage array; cleared on reset, written on the completing cycle of a good write.
   always_ff @(posedge i_PCLK) begin
      if (i_PRESET) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_commit) begin
`ifdef APB_MEM_PSTRB_EN
         for (int unsigned b = 0; b < NBYTES; b++) begin
            if (r_strb[b]) begin
               r_mem[r_idx][8*b +: 8] <= r_wdata[8*b +: 8];
            end
         end
`else
         r_mem[r_idx] <= r_wdata;
`endif
      end
   end

   assign io_apb.PRDATA  = r_prdata;
   assign io_apb.PREADY  = w_ready;
   assign io_apb.PSLVERR = w_ready & r_err;

endmodule

// File: tb/tb_apb_mem_ws.sv
// Directed bench for apb_mem_ws: three instances with 0, 3 and 2 wait states.
// Instance 0 uses a 12-bit address so out-of-range addresses can be exercised.
module tb_apb_mem_ws;
   logic        clk = 1'b0;
   logic        prst = 1'b1;
   logic [2:0]  sel = 3'b000;
   logic        penable = 1'b0;
   logic        pwrite = 1'b0;
   logic [11:0] paddr = '0;
   logic [31:0] pwdata = '0;
   logic [3:0]  pstrb = '0;
   logic [3:0]  pstrb_wr = 4'hF;
   logic [3:0]  pstrb_rd = 4'h0;

   int checks = 0;
   int failures = 0;

   logic [2:0]  rdy;
   logic [2:0]  slv;
   logic [31:0] rdata [3];

   int          waits;
   logic        err;
   logic [31:0] rd;

   always #5 clk = ~clk;

   apb_mem_ws_if #(.DATA_W(32), .ADDR_W(12)) if0 ();
   apb_mem_ws_if #(.DATA_W(32), .ADDR_W(8))  if3 ();
   apb_mem_ws_if #(.DATA_W(32), .ADDR_W(8))  if2 ();

   assign if0.PSEL = sel[0];  assign if3.PSEL = sel[1];  assign if2.PSEL = sel[2];
   assign if0.PENABLE = penable; assign if3.PENABLE = penable; assign if2.PENABLE = penable;
   assign if0.PWRITE = pwrite; assign if3.PWRITE = pwrite; assign if2.PWRITE = pwrite;
   assign if0.PADDR = paddr;  assign if3.PADDR = paddr[7:0]; assign if2.PADDR = paddr[7:0];
   assign if0.PWDATA = pwdata; assign if3.PWDATA = pwdata; assign if2.PWDATA = pwdata;
`ifdef APB_MEM_PSTRB_EN
   assign if0.PSTRB = pstrb;  assign if3.PSTRB = pstrb;  assign if2.PSTRB = pstrb;
`endif

   assign rdy = {if2.PREADY, if3.PREADY, if0.PREADY};
   assign slv = {if2.PSLVERR, if3.PSLVERR, if0.PSLVERR};
   assign rdata[0] = if0.PRDATA;
   assign rdata[1] = if3.PRDATA;
   assign rdata[2] = if2.PRDATA;

   apb_mem_ws #(.DATA_W(32), .ADDR_W(12), .DEPTH(64), .WAIT_CYCLES(0)) u_dut0 (
      .i_PCLK(clk), .i_PRESET(prst), .io_apb(if0));
   apb_mem_ws #(.DATA_W(32), .ADDR_W(8), .DEPTH(64), .WAIT_CYCLES(3)) u_dut3 (
      .i_PCLK(clk), .i_PRESET(prst), .io_apb(if3));
   apb_mem_ws #(.DATA_W(32), .ADDR_W(8), .DEPTH(64), .WAIT_CYCLES(2)) u_dut2 (
      .i_PCLK(clk), .i_PRESET(prst), .io_apb(if2));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Full setup + access transfer on instance k; returns wait count, PSLVERR and PRDATA.
   task automatic xfer(input int k, input logic wr, input logic [11:0] addr,
                       input logic [31:0] wd, output int nw, output logic e,
                       output logic [31:0] r);
      @(negedge clk);
      sel = 3'b000;
      sel[k] = 1'b1;
      penable = 1'b0;
      pwrite = wr;
      paddr = addr;
      pwdata = wd;
      pstrb = wr ? pstrb_wr : pstrb_rd;
      @(negedge clk);
      penable = 1'b1;
      #1;
      nw = 0;
      while (!rdy[k] && nw < 40) begin
         @(negedge clk);
         #1;
         nw++;
      end
      check("xfer_ready", {31'd0, rdy[k]}, 32'd1);
      e = slv[k];
      r = rdata[k];
      @(negedge clk);
      sel = 3'b000;
      penable = 1'b0;
   endtask

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready0", {29'd0, rdy}, 32'd0);
      check("rst_slverr", {29'd0, slv}, 32'd0);
      check("rst_prdata0", rdata[0], 32'd0);
      check("rst_prdata3", rdata[1], 32'd0);
      prst = 1'b0;

      // Zero-wait write then read
      xfer(0, 1'b1, 12'h010, 32'hDEADBEEF, waits, err, rd);
      check("w0_waits", waits, 0);
      check("w0_slverr", {31'd0, err}, 32'd0);
      xfer(0, 1'b0, 12'h010, 32'h0, waits, err, rd);
      check("r0_waits", waits, 0);
      check("r0_slverr", {31'd0, err}, 32'd0);
      check("r0_data", rd, 32'hDEADBEEF);

      // Three wait states on a post-reset read
      xfer(1, 1'b0, 12'h004, 32'h0, waits, err, rd);
      check("r3_waits", waits, 3);
      check("r3_data", rd, 32'd0);
      check("r3_slverr", {31'd0, err}, 32'd0);

      // Out-of-range write (index 64 aliases word 0 if not suppressed)
      xfer(0, 1'b1, 12'h100, 32'h11223344, waits, err, rd);
      check("oor_slverr", {31'd0, err}, 32'd1);
      xfer(0, 1'b0, 12'h000, 32'h0, waits, err, rd);
      check("oor_rd0_data", rd, 32'd0);
      check("oor_rd0_slverr", {31'd0, err}, 32'd0);

      // Misaligned reads return zero with error, even over stored data
      xfer(0, 1'b0, 12'h010, 32'h0, waits, err, rd);
      check("pre_mis_data", rd, 32'hDEADBEEF);
      xfer(0, 1'b0, 12'h012, 32'h0, waits, err, rd);
      check("mis12_slverr", {31'd0, err}, 32'd1);
      check("mis12_data", rd, 32'd0);
      xfer(0, 1'b0, 12'h002, 32'h0, waits, err, rd);
      check("mis02_slverr", {31'd0, err}, 32'd1);
      check("mis02_data", rd, 32'd0);
      @(negedge clk);
      #1;
      check("idle_slverr", {29'd0, slv}, 32'd0);
      check("idle_hold", rdata[0], 32'd0);

      // Abort a 2-wait write after one access cycle
      @(negedge clk);
      sel = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 12'h008;
      pwdata = 32'hCAFEF00D; pstrb = pstrb_wr;
      @(negedge clk);
      penable = 1'b1;
      #1;
      check("abort_acc1", {31'd0, rdy[2]}, 32'd0);
      @(negedge clk);
      sel = 3'b000; penable = 1'b0;
      #1;
      check("abort_drop", {31'd0, rdy[2]}, 32'd0);
      @(negedge clk);
      #1;
      check("abort_after", {31'd0, rdy[2]}, 32'd0);
      xfer(2, 1'b0, 12'h008, 32'h0, waits, err, rd);
      check("abort_rd_waits", waits, 2);
      check("abort_rd_data", rd, 32'd0);

`ifdef APB_MEM_PSTRB_EN
      // Byte strobes
      pstrb_wr = 4'hF;
      xfer(0, 1'b1, 12'h000, 32'hFFFFFFFF, waits, err, rd);
      pstrb_wr = 4'b0101;
      xfer(0, 1'b1, 12'h000, 32'h00000000, waits, err, rd);
      check("strb_w_slverr", {31'd0, err}, 32'd0);
      pstrb_wr = 4'hF;
      xfer(0, 1'b0, 12'h000, 32'h0, waits, err, rd);
      check("strb_rd_data", rd, 32'hFF00FF00);
      pstrb_rd = 4'b0001;
      xfer(0, 1'b0, 12'h000, 32'h0, waits, err, rd);
      check("strb_rd_slverr", {31'd0, err}, 32'd1);
      check("strb_rd_zero", rd, 32'd0);
      pstrb_rd = 4'h0;
`endif

      // Reset during the completing access cycle of a write
      xfer(0, 1'b0, 12'h010, 32'h0, waits, err, rd);
      check("pre_rst_data", rd, 32'hDEADBEEF);
      @(negedge clk);
      sel = 3'b001; penable = 1'b0; pwrite = 1'b1; paddr = 12'h00C;
      pwdata = 32'h5A5A5A5A; pstrb = pstrb_wr;
      @(negedge clk);
      penable = 1'b1;
      prst = 1'b1;
      #1;
      check("mid_rst_ready", {31'd0, rdy[0]}, 32'd1);
      @(negedge clk);
      #1;
      check("mid_rst_out_rdy", {31'd0, rdy[0]}, 32'd0);
      check("mid_rst_out_err", {31'd0, slv[0]}, 32'd0);
      check("mid_rst_out_data", rdata[0], 32'd0);
      prst = 1'b0;
      sel = 3'b000;
      penable = 1'b0;
      xfer(0, 1'b0, 12'h00C, 32'h0, waits, err, rd);
      check("mid_rst_rd0c", rd, 32'd0);
      xfer(0, 1'b0, 12'h010, 32'h0, waits, err, rd);
      check("mid_rst_rd10", rd, 32'd0);

      // Back-to-back on the 3-wait instance
      xfer(1, 1'b1, 12'h020, 32'h12345678, waits, err, rd);
      check("b2b_w_waits", waits, 3);
      xfer(1, 1'b0, 12'h020, 32'h0, waits, err, rd);
      check("b2b_r_data", rd, 32'h12345678);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global time limit
   initial begin
      #200000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/apb_mem_ws.md
Name: apb_mem_ws

Overview:
- Parametrised APB3 slave memory: the next generation of the team's fixed-size APB memory slave.
- Adds configurable data width and depth, programmable wait states, address-range and alignment error reporting, and protocol-abort handling.
- Sits directly on an APB bus as the single slave behind one PSEL line.
- Serves as the reference DUT for the class-based APB test environment.

Parameters:
- DATA_W, 32, data bus width in bits; legal values 8, 16, 32, 64.
- ADDR_W, 8, byte address width.
- DEPTH, 64, number of DATA_W-bit words; DEPTH*DATA_W/8 must not exceed 2^ADDR_W.
- WAIT_CYCLES, 0, number of wait states (_PREADY low) per access; legal range 0..15.

Ports:
- _PCLK  in  1  APB clock; the only clock.
- _PRESET  in  1  reset; synchronous, active-high.
- _PSEL  in  1  slave select.
- _PENABLE  in  1  access phase.
- _PWRITE  in  1  1 = write, 0 = read.
- _PADDR  in  ADDR_W  byte address.
- _PWDATA  in  DATA_W  write data.
- _PRDATA  out  DATA_W  read data.
- _PREADY  out  1  transfer complete.
- _PSLVERR  out  1  error response; valid only while _PREADY=1.

Behaviour:
- Clock and reset: one clock (_PCLK); reset _PRESET is synchronous and active-high.
- Reset, on any _PCLK edge with _PRESET=1:
  - state=IDLE, wait counter=0.
  - _PRDATA=0, _PREADY=0, _PSLVERR=0.
  - All memory words cleared to 0.
  - Applies even mid-access; any in-flight write is discarded.
- Addressing:
  - LSB = log2(DATA_W/8).
  - Word index = _PADDR[ADDR_W-1:LSB].
  - Misaligned: _PADDR[LSB-1:0] != 0 (never for DATA_W=8).
  - Out of range: index >= DEPTH.
  - Error = misaligned OR out of range.
- State machine: states IDLE and ACCESS.
- IDLE:
  - When _PSEL=1 and _PENABLE=0 (setup phase): latch _PADDR, _PWRITE, _PWDATA and the error flag; load counter=WAIT_CYCLES; go to ACCESS.
  - For a non-error read, register _PRDATA <= mem[index] on the same edge. For an error read, register _PRDATA <= 0.
  - _PSEL=1 with _PENABLE=1 while in IDLE is ignored (stay IDLE).
- ACCESS:
  - Requires _PSEL=1 and _PENABLE=1.
  - _PREADY = (state==ACCESS) & (counter==0). This is a decode of registered state only, with no input-to-output combinational path.
  - counter != 0: decrement; _PREADY=0.
  - counter == 0: _PREADY=1, _PSLVERR = latched error flag. On that edge:
    - Non-error write: mem[index] <= latched wdata.
    - Go to IDLE.
  - Error writes never modify memory.
- Abort: in ACCESS, if _PSEL=0 or _PENABLE=0, go to IDLE on the next edge. No write occurs, and _PREADY is never asserted for that transfer.
- Latency: an access phase lasts WAIT_CYCLES+1 cycles. Back-to-back transfers are supported (setup immediately after the completing cycle).
- Between transfers:
  - _PSLVERR=0 whenever _PREADY=0.
  - _PRDATA holds its last value until the next read setup.

Optional Feature:
- Macro: APB_MEM_PSTRB_EN.
- Defined:
  - Adds input port _PSTRB, width DATA_W/8, latched at setup.
  - On a non-error write, byte lane i updates only if strobe bit i is 1. _PSTRB=0 makes the write a no-op with no error.
  - A read with _PSTRB != 0 completes with _PSLVERR=1 and _PRDATA=0.
- Undefined:
  - No _PSTRB port.
  - Every non-error write updates the full word.

Test Plan:
- Reset then idle, DATA_W=32, WAIT_CYCLES=0: write 0xDEADBEEF to 0x10, then read 0x10 → write _PREADY=1 in the first access cycle, _PSLVERR=0; read _PRDATA=0xDEADBEEF.
- WAIT_CYCLES=3: read 0x04 → _PREADY low for 3 access cycles and high on the 4th, _PRDATA=0 (post-reset).
- Error cases, DEPTH=64:
  - Write 0x11223344 to 0x100 (out of range) → _PSLVERR=1 with _PREADY=1; a subsequent read of 0x00 returns 0.
  - Read 0x02 (misaligned) → _PSLVERR=1, _PRDATA=0.
- Abort: write 0xCAFEF00D to 0x08 with WAIT_CYCLES=2, drop _PSEL after one access cycle → _PREADY never asserted; a later read of 0x08 returns 0.
- Reset mid-operation: assert _PRESET during the access phase of a write 0x5A5A5A5A to 0x0C → all outputs 0 next cycle; a read of 0x0C returns 0.
- APB_MEM_PSTRB_EN: write 0xFFFFFFFF to 0x00, then write 0x00000000 with _PSTRB=4'b0101 → read 0x00 = 0xFF00FF00; a read with _PSTRB=4'b0001 → _PSLVERR=1.
